// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the four-digit MM:SS stopwatch counter.
//
// Purpose
//   This block conditions the raw pause and clear buttons, generates the count
//   tick and the adjust/blink timebase, and runs the PAUSED/RUN/ADJUST mode FSM.
//   In ADJUST it computes the incremented value of the selected digit, which
//   the counter then loads.
//
// Optional feature
//   Define STOPWATCH_CTRL_DEBOUNCE_EN to add a DB_CYCLES debouncer per button.
//   When the macro is not defined, DB_CYCLES is unused.
//
// Ports
//   clk_i, rst_i          clock and synchronous active-high reset
//   btn_pause_i/btn_clr_i raw asynchronous buttons, active-high
//   sw_adj_i              adjust-mode switch (level)
//   sw_sel_i[1:0]         digit select: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens
//   dig0_i..dig3_i        current counter digits
//   cnt_tick_o            one-cycle count enable
//   cnt_clr_o             one-cycle clear
//   cnt_adj_o             high while in ADJUST
//   cnt_sel_o[1:0]        registered digit select
//   cnt_load_o            one-cycle load strobe
//   cnt_num_o[3:0]        load value
//   blink_on_o            display enable for the selected digit (0 = blanked)
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned ADJ_DIV   = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_pause_i,
  input  logic       btn_clr_i,
  input  logic       sw_adj_i,
  input  logic [1:0] sw_sel_i,
  input  logic [3:0] dig0_i,
  input  logic [2:0] dig1_i,
  input  logic [3:0] dig2_i,
  input  logic [2:0] dig3_i,
  output logic       cnt_tick_o,
  output logic       cnt_clr_o,
  output logic       cnt_adj_o,
  output logic [1:0] cnt_sel_o,
  output logic       cnt_load_o,
  output logic [3:0] cnt_num_o,
  output logic       blink_on_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ADJ_DIV  > 1) ? $clog2(ADJ_DIV)  : 1;

  typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_e;
  state_e state_q, state_d;

  // Button conditioning; bit 0 is pause, bit 1 is clear.
  logic [1:0] sync1_q, sync2_q, lvl_q, prev_q, evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {btn_clr_i, btn_pause_i};
      sync2_q <= sync1_q;
      prev_q  <= lvl_q;
    end
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  logic [DW-1:0] db_cnt_q [2];

  // The level follows the synchronized input only after it has disagreed for
  // a full DB_CYCLES run; any agreeing sample restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != lvl_q[i]) begin
          if (db_cnt_q[i] == DW'(DB_CYCLES)) begin
            lvl_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) lvl_q <= '0;
    else       lvl_q <= sync2_q;
  end
`endif

  assign evt = lvl_q & ~prev_q;

  logic pause_evt, clr_evt;
  assign pause_evt = evt[0];
  assign clr_evt   = evt[1];

  // The switch is used raw so that the mode changes on the first edge that
  // samples it; it also takes priority over a coincident pause event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSED:  if (sw_adj_i) state_d = ADJUST; else if (pause_evt) state_d = RUN;
      RUN:     if (sw_adj_i) state_d = ADJUST; else if (pause_evt) state_d = PAUSED;
      ADJUST:  if (!sw_adj_i) state_d = PAUSED;
      default: state_d = PAUSED;
    endcase
  end

  // Next value of the selected digit: the tens digits wrap at 5, the ones
  // digits at 9, and anything at or beyond the limit reloads as 0.
  logic [3:0] sel_dig, sel_max, nxt_dig;
  always_comb begin
    sel_dig = '0;
    sel_max = 4'd9;
    case (sw_sel_i)
      2'd0: begin sel_dig = dig0_i;         sel_max = 4'd9; end
      2'd1: begin sel_dig = {1'b0, dig1_i}; sel_max = 4'd5; end
      2'd2: begin sel_dig = dig2_i;         sel_max = 4'd9; end
      default: begin sel_dig = {1'b0, dig3_i}; sel_max = 4'd5; end
    endcase
    nxt_dig = (sel_dig >= sel_max) ? 4'd0 : sel_dig + 4'd1;
  end

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [AW-1:0] adj_cnt_q, adj_cnt_d;
  logic          tick_hit, adj_hit;

  assign tick_hit = (state_q == RUN)    && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign adj_hit  = (state_q == ADJUST) && (adj_cnt_q  == AW'(ADJ_DIV - 1));

  // Both dividers are held at 0 outside their own state, so every entry
  // starts a full period.
  always_comb begin
    tick_cnt_d = '0;
    adj_cnt_d  = '0;
    if (state_q == RUN && !tick_hit)   tick_cnt_d = tick_cnt_q + 1'b1;
    if (state_q == ADJUST && !adj_hit) adj_cnt_d  = adj_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PAUSED;
      tick_cnt_q <= '0;
      adj_cnt_q  <= '0;
      cnt_tick_o <= 1'b0;
      cnt_clr_o  <= 1'b0;
      cnt_adj_o  <= 1'b0;
      cnt_sel_o  <= '0;
      cnt_load_o <= 1'b0;
      cnt_num_o  <= '0;
      blink_on_o <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      adj_cnt_q  <= adj_cnt_d;
      // Clear wins over a coincident tick or load for that cycle only.
      cnt_tick_o <= tick_hit & ~clr_evt;
      cnt_clr_o  <= clr_evt;
      cnt_adj_o  <= (state_q == ADJUST);
      cnt_sel_o  <= sw_sel_i;
      cnt_load_o <= adj_hit & ~clr_evt;
      if (adj_hit && !clr_evt) cnt_num_o <= nxt_dig;
      if (state_q != ADJUST) blink_on_o <= 1'b1;
      else if (adj_hit)      blink_on_o <= ~blink_on_o;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  localparam int TICK_DIV  = 10;
  localparam int ADJ_DIV   = 4;
  localparam int DB_CYCLES = 8;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int LAT = DB_CYCLES + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       btn_pause = 1'b0, btn_clr = 1'b0, sw_adj = 1'b0;
  logic [1:0] sw_sel = 2'd0;
  logic [3:0] dig0 = 4'd0, dig2 = 4'd0;
  logic [2:0] dig1 = 3'd0, dig3 = 3'd0;
  logic       cnt_tick, cnt_clr, cnt_adj, cnt_load, blink_on;
  logic [1:0] cnt_sel;
  logic [3:0] cnt_num;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .ADJ_DIV(ADJ_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk_i(clk), .rst_i(rst), .btn_pause_i(btn_pause), .btn_clr_i(btn_clr),
    .sw_adj_i(sw_adj), .sw_sel_i(sw_sel), .dig0_i(dig0), .dig1_i(dig1),
    .dig2_i(dig2), .dig3_i(dig3), .cnt_tick_o(cnt_tick), .cnt_clr_o(cnt_clr),
    .cnt_adj_o(cnt_adj), .cnt_sel_o(cnt_sel), .cnt_load_o(cnt_load),
    .cnt_num_o(cnt_num), .blink_on_o(blink_on)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cy();
    @(posedge clk); #1;
  endtask

  initial begin
    int sel_now;
    int nexp;

    // reset state
    cy(); cy();
    chk("rst_tick", cnt_tick, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_adj", cnt_adj, 0);
    chk("rst_sel", cnt_sel, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_num", cnt_num, 0);
    chk("rst_blink", blink_on, 1);
    rst = 1'b0;

    // pause -> RUN; ticks every 10; clear lands on a tick cycle
    btn_pause = 1'b1;
    for (int n = 1; n <= LAT + 55; n++) begin
      cy();
      chk("run_tick", cnt_tick,
          (n >= LAT + 11 && (n - LAT - 11) % 10 == 0 && n != LAT + 41) ? 1 : 0);
      chk("run_clr", cnt_clr, (n == LAT + 41) ? 1 : 0);
      if (n == LAT + 2) btn_pause = 1'b0;
      if (n == 40) btn_clr = 1'b1;
      if (n == 40 + LAT + 2) btn_clr = 1'b0;
    end
    chk("run_adj", cnt_adj, 0);
    chk("run_blink", blink_on, 1);

    // second press -> PAUSED, no more ticks
    btn_pause = 1'b1;
    for (int i = 1; i <= LAT + 12; i++) begin
      cy();
      if (i == LAT + 2) btn_pause = 1'b0;
    end
    for (int i = 0; i < 25; i++) begin
      cy(); chk("pause_off_tick", cnt_tick, 0);
    end

    // ADJUST: loads every 4 cycles, digit wrap, blink, ignored pause
    sw_sel = 2'd1; dig1 = 3'd5; sw_adj = 1'b1;
    for (int m = 1; m <= 26; m++) begin
      sel_now = int'(sw_sel);
      cy();
      chk("adj_lvl", cnt_adj, (m >= 2) ? 1 : 0);
      chk("adj_sel", cnt_sel, sel_now);
      chk("adj_load", cnt_load, (m >= 5 && m % 4 == 1) ? 1 : 0);
      chk("adj_blink", blink_on, (m < 5) ? 1 : ((((m - 5) / 4) % 2 == 0) ? 0 : 1));
      case (m)
        5, 9, 17, 21: chk("adj_num", cnt_num, 0);
        13:           chk("adj_num", cnt_num, 4);
        25:           chk("adj_num", cnt_num, 9);
        default: ;
      endcase
      case (m)
        6:  btn_pause = 1'b1;
        9:  dig1 = 3'd3;
        13: begin sw_sel = 2'd0; dig0 = 4'd9; end
        17: dig0 = 4'd12;
        21: begin sw_sel = 2'd2; dig2 = 4'd8; end
        default: ;
      endcase
      if (m == 6 + LAT + 2) btn_pause = 1'b0;
    end

    // leave ADJUST -> PAUSED, never RUN
    sw_adj = 1'b0;
    cy(); cy();
    chk("adj_exit_lvl", cnt_adj, 0);
    chk("adj_exit_blink", blink_on, 1);
    for (int i = 0; i < 20; i++) begin
      cy(); chk("adj_exit_tick", cnt_tick, 0);
    end

    // RUN -> ADJUST -> PAUSED
    btn_pause = 1'b1;
    for (int n = 1; n <= LAT + 11; n++) begin
      cy();
      chk("rerun_tick", cnt_tick, (n == LAT + 11) ? 1 : 0);
      if (n == LAT + 2) btn_pause = 1'b0;
    end
    sw_adj = 1'b1;
    cy(); cy();
    chk("run_adj_lvl", cnt_adj, 1);
    for (int i = 0; i < 15; i++) begin
      cy(); chk("run_adj_tick", cnt_tick, 0);
    end
    sw_adj = 1'b0;
    cy(); cy();
    chk("run_adj_exit_lvl", cnt_adj, 0);
    chk("run_adj_exit_blink", blink_on, 1);
    for (int i = 0; i < 25; i++) begin
      cy(); chk("run_adj_exit_tick", cnt_tick, 0);
    end

    // reset mid-RUN returns to PAUSED with outputs at reset values
    btn_pause = 1'b1;
    for (int i = 1; i <= LAT + 5; i++) begin
      cy();
      if (i == LAT + 2) btn_pause = 1'b0;
    end
    rst = 1'b1;
    cy();
    rst = 1'b0;
    chk("mid_rst_tick", cnt_tick, 0);
    chk("mid_rst_clr", cnt_clr, 0);
    chk("mid_rst_num", cnt_num, 0);
    chk("mid_rst_blink", blink_on, 1);
    for (int i = 0; i < 25; i++) begin
      cy(); chk("mid_rst_run", cnt_tick, 0);
    end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    // short glitch is swallowed by the debouncer
    btn_clr = 1'b1;
    for (int i = 0; i < 5; i++) cy();
    btn_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cy(); chk("glitch_clr", cnt_clr, 0);
    end
`endif

    // clear latency and single pulse per press
    btn_clr = 1'b1;
    nexp = 0;
    for (int n = 1; n <= LAT + 10; n++) begin
      cy();
      chk("clr_lat", cnt_clr, (n == LAT + 1) ? 1 : 0);
      if (n == LAT + 1) nexp++;
    end
    btn_clr = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      cy(); chk("clr_release", cnt_clr, 0);
    end
    chk("clr_pulses", nexp, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
